// File: rtl/mont_exp_engine.sv
// mont_exp_engine: Z = X^E mod M using one time-shared radix-2 Montgomery multiplier.
// R^2 mod M (R = 2^BITS) is built on the fly by modular doubling, so any odd M >= 3 works.
// Build macro MONTEXP_LZ_SKIP_EN: when defined, leading zero exponent bits are skipped and
// the multiply step runs only for set bits (data-dependent latency). When undefined the
// engine is constant-time: done rises a fixed number of edges after the accept edge.
//
// state     | meaning
// IDLE      | waiting for go; done/err/Z hold the last result
// CHK_ERR   | modulus rejected at accept; err/done raised on the next edge
// PRE       | 2*BITS modular doublings of 1 -> R^2 mod M
// TOMONT_X  | Xm = MM(X, R2)
// TOMONT_1  | A  = MM(1, R2)
// SQR       | A  = MM(A, A)
// MUL       | A  = E[i] ? MM(A, Xm) : A
// FROMONT   | A  = MM(A, 1), leaves the Montgomery domain
// FIN       | publish Z, raise done, drop busy
module mont_exp_engine #(
  parameter int BITS     = 32,
  parameter int EXP_BITS = BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [BITS-1:0]     X,
  input  logic [EXP_BITS-1:0] E,
  input  logic [BITS-1:0]     M,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BITS-1:0]     Z
);

  localparam int CW = $clog2(2*BITS + 1);
  localparam int IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  typedef enum logic [3:0] {
    IDLE, CHK_ERR, PRE, TOMONT_X, TOMONT_1, SQR, MUL, FROMONT, FIN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BITS-1:0]     x_q, x_d, m_q, m_d, r_q, r_d, xm_q, xm_d, a_q, a_d, z_q, z_d;
  logic [EXP_BITS-1:0] e_q, e_d;
  logic [BITS+1:0]     t_q, t_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                m_bad, cnt_zero, last_bit, e_bit, a_bit, run_mul, skip_all;
  logic [IW-1:0]       start_idx;
  logic [CW-1:0]       bit_pos;
  logic [BITS-1:0]     a_sel, b_sel, r_step, mm_res;
  logic [BITS:0]       r_dbl;
  logic [BITS+1:0]     t_add, t_odd, t_step;

  assign m_bad    = ~M[0] | (M == BITS'(1));
  assign cnt_zero = (cnt_q == '0);
  assign last_bit = (idx_q == '0);
  assign bit_pos  = CW'(BITS) - cnt_q;

`ifdef MONTEXP_LZ_SKIP_EN
  // Ladder starts at the highest set exponent bit; multiply only where the bit is set.
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < EXP_BITS; i++)
      if (e_q[i]) start_idx = IW'(i);
  end
  assign skip_all = (e_q == '0);
  assign run_mul  = e_bit;
`else
  assign start_idx = IW'(EXP_BITS - 1);
  assign skip_all  = 1'b0;
  assign run_mul   = 1'b1;
`endif

  // Current exponent bit selected by idx_q.
  always_comb begin
    e_bit = 1'b0;
    for (int i = 0; i < EXP_BITS; i++)
      if (IW'(i) == idx_q) e_bit = e_q[i];
  end

  // Multiplier operands for the product phase in progress.
  always_comb begin
    a_sel = a_q;
    b_sel = a_q;
    case (state_q)
      TOMONT_X: begin a_sel = x_q;      b_sel = r_q;      end
      TOMONT_1: begin a_sel = BITS'(1); b_sel = r_q;      end
      MUL:      b_sel = xm_q;
      FROMONT:  b_sel = BITS'(1);
      default:  ;
    endcase
  end

  // Multiplier bit of operand a consumed this cycle (LSB first).
  always_comb begin
    a_bit = 1'b0;
    for (int i = 0; i < BITS; i++)
      if (CW'(i) == bit_pos) a_bit = a_sel[i];
  end

  // t stays below 2M, so t + b + M < 4M fits in BITS+2 bits even for M = 2^BITS-1.
  assign t_add  = t_q + (a_bit ? {2'b00, b_sel} : '0);
  assign t_odd  = t_add + (t_add[0] ? {2'b00, m_q} : '0);
  assign t_step = t_odd >> 1;
  assign mm_res = (t_q >= {2'b00, m_q}) ? (t_q[BITS-1:0] - m_q) : t_q[BITS-1:0];

  assign r_dbl  = {r_q, 1'b0};
  assign r_step = (r_dbl >= {1'b0, m_q}) ? BITS'(r_dbl - {1'b0, m_q}) : r_dbl[BITS-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; every product phase ends on the counter's terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (go) state_d = m_bad ? CHK_ERR : PRE;
      CHK_ERR:  state_d = IDLE;
      PRE:      if (cnt_zero) state_d = TOMONT_X;
      TOMONT_X: if (cnt_zero) state_d = TOMONT_1;
      TOMONT_1: if (cnt_zero) state_d = skip_all ? FROMONT : SQR;
      SQR:      if (cnt_zero) state_d = run_mul ? MUL : (last_bit ? FROMONT : SQR);
      MUL:      if (cnt_zero) state_d = last_bit ? FROMONT : SQR;
      FROMONT:  if (cnt_zero) state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and output next values for the current state.
  always_comb begin
    cnt_d  = cnt_q;  idx_d  = idx_q;
    x_d    = x_q;    e_d    = e_q;    m_d = m_q;
    r_d    = r_q;    xm_d   = xm_q;   a_d = a_q;  t_d = t_q;
    busy_d = busy_q; done_d = done_q; err_d = err_q; z_d = z_q;
    case (state_q)
      IDLE: if (go) begin
        x_d    = X;  e_d = E;  m_d = M;
        busy_d = 1'b1; done_d = 1'b0; err_d = 1'b0;
        r_d    = BITS'(1);
        cnt_d  = CW'(2*BITS - 1);
      end
      CHK_ERR: begin
        busy_d = 1'b0; done_d = 1'b1; err_d = 1'b1; z_d = '0;
      end
      PRE: begin
        r_d = r_step;
        if (cnt_zero) begin
          cnt_d = CW'(BITS);
          t_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TOMONT_X, TOMONT_1, SQR, MUL, FROMONT: begin
        if (!cnt_zero) begin
          t_d   = t_step;
          cnt_d = cnt_q - CW'(1);
        end else begin
          t_d   = '0;
          cnt_d = CW'(BITS);
          case (state_q)
            TOMONT_X: xm_d = mm_res;
            TOMONT_1: begin a_d = mm_res; idx_d = start_idx; end
            SQR: begin
              a_d = mm_res;
              if (!run_mul && !last_bit) idx_d = idx_q - IW'(1);
            end
            MUL: begin
              if (e_bit) a_d = mm_res;
              if (!last_bit) idx_d = idx_q - IW'(1);
            end
            FROMONT:  a_d = mm_res;
            default:  ;
          endcase
        end
      end
      FIN: begin
        busy_d = 1'b0; done_d = 1'b1; z_d = a_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0; idx_q <= '0;
      x_q    <= '0; e_q   <= '0; m_q <= '0;
      r_q    <= '0; xm_q  <= '0; a_q <= '0; t_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; z_q <= '0;
    end else begin
      cnt_q  <= cnt_d;  idx_q  <= idx_d;
      x_q    <= x_d;    e_q    <= e_d;    m_q <= m_d;
      r_q    <= r_d;    xm_q   <= xm_d;   a_q <= a_d;  t_q <= t_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d; z_q <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_mont_exp_engine.sv
// Scoreboard bench for mont_exp_engine: a 32-bit and a 64-bit instance, expected
// results from a plain square-and-multiply model, checked by per-instance monitors.
module tb_mont_exp_engine;

  localparam int B1   = 32;
  localparam int B2   = 64;
  localparam int LAT1 = 2*B1 + (B1+1)*(2*B1+3) + 1;
  localparam int LAT2 = 2*B2 + (B2+1)*(2*B2+3) + 1;
`ifdef MONTEXP_LZ_SKIP_EN
  localparam int EXP_LAT1 = -1;
  localparam int EXP_LAT2 = -1;
`else
  localparam int EXP_LAT1 = LAT1;
  localparam int EXP_LAT2 = LAT2;
`endif
  localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFC5;

  typedef struct {
    logic [63:0] z;
    logic        err;
    longint      acc;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go1 = 1'b0, go2 = 1'b0;
  logic [B1-1:0] x1 = '0, e1 = '0, m1 = '0, z1;
  logic [B2-1:0] x2 = '0, e2 = '0, m2 = '0, z2;
  logic          busy1, done1, err1, busy2, done2, err2;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  longint last_lat1 = 0, lat_a = 0, lat_b = 0;
  exp_t   q1[$], q2[$];
  exp_t   ex1, ex2;
  logic   done1_prev = 1'b0, done2_prev = 1'b0;
  logic [31:0] rx, re, rm;

  mont_exp_engine #(.BITS(B1), .EXP_BITS(B1)) dut (
    .clk(clk), .rst(rst), .go(go1), .X(x1), .E(e1), .M(m1),
    .busy(busy1), .done(done1), .err(err1), .Z(z1));

  mont_exp_engine #(.BITS(B2), .EXP_BITS(B2)) dut64 (
    .clk(clk), .rst(rst), .go(go2), .X(x2), .E(e2), .M(m2),
    .busy(busy2), .done(done2), .err(err2), .Z(z2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain binary exponentiation with wide integers.
  function automatic logic [63:0] ref_exp(input logic [63:0] x, input logic [63:0] e,
                                          input logic [63:0] m);
    logic [127:0] acc, base, mm;
    mm   = {64'd0, m};
    acc  = 128'd1 % mm;
    base = {64'd0, x} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) acc = (acc * base) % mm;
      base = (base * base) % mm;
    end
    return acc[63:0];
  endfunction

  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done32_unexpected: got done with Z=0x%0h, expected no result", z1);
      end else begin
        ex1 = q1.pop_front();
        last_lat1 = cyc - ex1.acc;
        chk("z32", 64'(z1), ex1.z);
        chk("err32", 64'(err1), 64'(ex1.err));
        chk("busy_at_done32", 64'(busy1), 64'd0);
        if (ex1.lat >= 0) chk("lat32", 64'(last_lat1), 64'(ex1.lat));
      end
    end
    done1_prev <= done1;
  end

  always @(negedge clk) begin
    if (done2 && !done2_prev) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done64_unexpected: got done with Z=0x%0h, expected no result", z2);
      end else begin
        ex2 = q2.pop_front();
        chk("z64", z2, ex2.z);
        chk("err64", 64'(err2), 64'(ex2.err));
        chk("busy_at_done64", 64'(busy2), 64'd0);
        if (ex2.lat >= 0) chk("lat64", 64'(cyc - ex2.acc), 64'(ex2.lat));
      end
    end
    done2_prev <= done2;
  end

  task automatic start1(input logic [31:0] x, input logic [31:0] e, input logic [31:0] m,
                        input logic [63:0] ez, input logic eerr, input int lat);
    exp_t ex;
    int n = 0;
    @(negedge clk);
    while (busy1 && n < LAT1 + 100) begin @(negedge clk); n++; end
    x1 = x; e1 = e; m1 = m; go1 = 1'b1;
    ex.z = ez; ex.err = eerr; ex.lat = lat; ex.acc = cyc + 1;
    q1.push_back(ex);
    @(negedge clk);
    go1 = 1'b0; x1 = $urandom; e1 = $urandom; m1 = $urandom;
  endtask

  task automatic wait1(input string name);
    int n = 0;
    while (!done1 && n < LAT1 + 100) begin @(negedge clk); n++; end
    if (!done1) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected done=1", name, n);
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic run1(input string name, input logic [31:0] x, input logic [31:0] e,
                      input logic [31:0] m, input logic [63:0] ez, input logic eerr,
                      input int lat);
    start1(x, e, m, ez, eerr, lat);
    wait1(name);
  endtask

  task automatic run2(input string name, input logic [63:0] x, input logic [63:0] e,
                      input logic [63:0] m, input logic [63:0] ez);
    exp_t ex;
    int n = 0;
    @(negedge clk);
    x2 = x; e2 = e; m2 = m; go2 = 1'b1;
    ex.z = ez; ex.err = 1'b0; ex.lat = EXP_LAT2; ex.acc = cyc + 1;
    q2.push_back(ex);
    @(negedge clk);
    go2 = 1'b0; x2 = {$urandom, $urandom}; e2 = '0; m2 = '0;
    while (!done2 && n < LAT2 + 100) begin @(negedge clk); n++; end
    if (!done2) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected done=1", name, n);
      q2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_err",  64'(err1),  64'd0);
    chk("rst_z",    64'(z1),    64'd0);
    chk("rst_z64",  z2,         64'd0);
    rst = 1'b0;

    run1("basic", 32'd456, 32'd3, 32'd1189, 64'd822, 1'b0, EXP_LAT1);
    repeat (5) @(negedge clk);
    chk("done_hold", 64'(done1), 64'd1);
    chk("z_hold",    64'(z1),    64'd822);

    run1("rsa_enc", 32'd65,   32'd17,   32'd3233, 64'd2790, 1'b0, EXP_LAT1);
    run1("rsa_dec", 32'd2790, 32'd2753, 32'd3233, 64'd65,   1'b0, EXP_LAT1);
    run1("e_zero",  32'd1234, 32'd0,    32'd3233, 64'd1,    1'b0, EXP_LAT1);
    run1("m_even",  32'd1234, 32'd7,    32'd1000, 64'd0,    1'b1, 1);
    run1("m_one",   32'd5,    32'd7,    32'd1,    64'd0,    1'b1, 1);
    run1("x_zero",  32'd0,    32'd7,    32'd1189, 64'd0,    1'b0, EXP_LAT1);
    run1("x_eq_m",  32'd1189, 32'd5,    32'd1189, 64'd0,    1'b0, EXP_LAT1);

    // go while busy must be ignored
    start1(32'd456, 32'd3, 32'd1189, 64'd822, 1'b0, EXP_LAT1);
    repeat (100) @(negedge clk);
    x1 = 32'd999; e1 = 32'd5; m1 = 32'd3233; go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    chk("busy_midrun", 64'(busy1), 64'd1);
    wait1("ignore_go");

    // reset mid-run aborts and clears every output
    start1(32'd65, 32'd17, 32'd3233, 64'd2790, 1'b0, EXP_LAT1);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    q1.delete();
    #1;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    chk("abort_err",  64'(err1),  64'd0);
    chk("abort_z",    64'(z1),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    run1("after_rst", 32'd65, 32'd17, 32'd3233, 64'd2790, 1'b0, EXP_LAT1);

    for (int i = 0; i < 8; i++) begin
      rm = $urandom | 32'd1;
      if (rm < 32'd3) rm = 32'd3;
      if (i == 0) rm = 32'hFFFF_FFFF;
      rx = $urandom;
      re = (i % 3 == 1) ? $urandom_range(0, 40) : $urandom;
      if (i == 6) begin
        rx = rm;
        if (re == 32'd0) re = 32'd1;
      end
      if (i == 5) begin
        rm = $urandom & ~32'd1;
        run1("rand_bad_m", rx, re, rm, 64'd0, 1'b1, 1);
      end else begin
        run1("rand", rx, re, rm, ref_exp(64'(rx), 64'(re), 64'(rm)), 1'b0, EXP_LAT1);
      end
    end

    run1("e_one", 32'd5, 32'd1, 32'd3233, 64'd5, 1'b0, EXP_LAT1);
    lat_a = last_lat1;
    run1("e_msb", 32'd5, 32'h8000_0000, 32'd3233,
         ref_exp(64'd5, 64'h8000_0000, 64'd3233), 1'b0, EXP_LAT1);
    lat_b = last_lat1;
`ifdef MONTEXP_LZ_SKIP_EN
    chk("lz_e1_shorter", 64'(lat_a < lat_b), 64'd1);
`endif

    run2("m64_xm1", M64 - 64'd1, 64'd2, M64, 64'd1);
    run2("m64_xm",  M64,         64'd5, M64, 64'd0);

    repeat (3) @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q1.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
